// File: rtl/axis_layer_sequencer_pkg.sv
// Shared state encoding and sizing helpers for axis_layer_sequencer.
package axis_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Address width for an n-word buffer; never narrower than one bit.
    function automatic int unsigned adr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned group_size(input int unsigned in_n, input int unsigned out_n);
        return in_n / out_n;
    endfunction

endpackage

// File: rtl/axis_layer_sequencer_counter.sv
// Saturating up-counter with a sticky flag raised by an increment at the terminal value.
module Counter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MAX_VAL = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             full
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;

    always_comb begin
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clr) begin
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (inc && !full_q) begin
            // The count parks at the terminal value; the last increment only raises full.
            if (cnt_q == MAX_C) begin
                full_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX_C);
    assign full   = full_q;

endmodule

// File: rtl/axis_layer_sequencer.sv
// Walks the input buffer into a PE, collects its results into the output buffer, pulses done.
// Optional feature: define SEQ_PERF_CNT_EN to add the 32-bit perf_cycles job cycle counter.
module axis_layer_sequencer
    import axis_seq_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned IN_DATA_NUM  = 8,
    parameter  int unsigned OUT_DATA_NUM = 4,
    localparam int unsigned IN_ADR_W     = adr_width(IN_DATA_NUM),
    localparam int unsigned OUT_ADR_W    = adr_width(OUT_DATA_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  axisif_start,
    output logic                  axisif_done,
    output logic [IN_ADR_W-1:0]   axisif_bufferIn_adr,
    input  logic [DATA_WIDTH-1:0] axisif_bufferIn_data,
    output logic [OUT_ADR_W-1:0]  axisif_bufferOut_adr,
    output logic [DATA_WIDTH-1:0] axisif_bufferOut_data,
    output logic                  axisif_bufferOut_wr,
    output logic                  pe_in_valid,
    input  logic                  pe_in_ready,
    output logic [DATA_WIDTH-1:0] pe_in_data,
    output logic                  pe_in_first,
    output logic                  pe_in_last,
    input  logic                  pe_out_valid,
    input  logic [DATA_WIDTH-1:0] pe_out_data
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam int unsigned GROUP = group_size(IN_DATA_NUM, OUT_DATA_NUM);

    seq_state_e state_q, state_d;

    logic [IN_ADR_W-1:0]  in_cnt;
    logic [OUT_ADR_W-1:0] out_cnt;
    logic                 in_at_max, in_full;
    logic                 out_at_max, out_full;
    logic                 cnt_clr;
    logic                 in_accept;
    logic                 in_final;
    logic                 out_wr;
    logic                 out_final;
    logic [IN_ADR_W-1:0]  grp_pos;

    assign cnt_clr = (state_q == ST_IDLE);

    Counter #(
        .WIDTH   (IN_ADR_W),
        .MAX_VAL (IN_DATA_NUM - 1)
    ) u_in_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .inc    (in_accept),
        .cnt    (in_cnt),
        .at_max (in_at_max),
        .full   (in_full)
    );

    Counter #(
        .WIDTH   (OUT_ADR_W),
        .MAX_VAL (OUT_DATA_NUM - 1)
    ) u_out_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .inc    (out_wr),
        .cnt    (out_cnt),
        .at_max (out_at_max),
        .full   (out_full)
    );

    assign pe_in_valid = (state_q == ST_RUN) && !in_full;
    assign in_accept   = pe_in_valid && pe_in_ready;
    assign in_final    = in_accept && in_at_max;

    assign grp_pos     = IN_ADR_W'(32'(in_cnt) % GROUP);
    assign pe_in_first = pe_in_valid && (grp_pos == '0);
    assign pe_in_last  = pe_in_valid && (grp_pos == IN_ADR_W'(GROUP - 1));
    assign pe_in_data  = axisif_bufferIn_data;

    assign axisif_bufferIn_adr = in_cnt;

    assign out_wr    = pe_out_valid && !out_full &&
                       ((state_q == ST_RUN) || (state_q == ST_FLUSH));
    assign out_final = out_wr && out_at_max;

    assign axisif_bufferOut_wr   = out_wr;
    assign axisif_bufferOut_adr  = out_cnt;
    assign axisif_bufferOut_data = out_wr ? pe_out_data : '0;

    assign axisif_done = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (axisif_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Results can finish before or with the last beat; skip FLUSH then.
                if (in_final) begin
                    state_d = (out_full || out_final) ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (out_final || out_full) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE) begin
            if (axisif_start) begin
                perf_d = '0;
            end
        end else if (perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_axis_layer_sequencer.sv
// Self-checking bench for axis_layer_sequencer: transaction-level model, emulated PE, directed jobs.
module tb_axis_layer_sequencer;

    localparam int IN_N  = 8;
    localparam int OUT_N = 4;
    localparam int G     = IN_N / OUT_N;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        axisif_start;
    logic        axisif_done;
    logic [2:0]  axisif_bufferIn_adr;
    logic [31:0] axisif_bufferIn_data;
    logic [1:0]  axisif_bufferOut_adr;
    logic [31:0] axisif_bufferOut_data;
    logic        axisif_bufferOut_wr;
    logic        pe_in_valid;
    logic        pe_in_ready;
    logic [31:0] pe_in_data;
    logic        pe_in_first;
    logic        pe_in_last;
    logic        pe_out_valid;
    logic [31:0] pe_out_data;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    logic [31:0] in_mem  [IN_N];
    logic [31:0] out_mem [OUT_N];

    assign axisif_bufferIn_data = in_mem[axisif_bufferIn_adr];

    axis_layer_sequencer #(
        .DATA_WIDTH   (32),
        .IN_DATA_NUM  (IN_N),
        .OUT_DATA_NUM (OUT_N)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .axisif_start          (axisif_start),
        .axisif_done           (axisif_done),
        .axisif_bufferIn_adr   (axisif_bufferIn_adr),
        .axisif_bufferIn_data  (axisif_bufferIn_data),
        .axisif_bufferOut_adr  (axisif_bufferOut_adr),
        .axisif_bufferOut_data (axisif_bufferOut_data),
        .axisif_bufferOut_wr   (axisif_bufferOut_wr),
        .pe_in_valid           (pe_in_valid),
        .pe_in_ready           (pe_in_ready),
        .pe_in_data            (pe_in_data),
        .pe_in_first           (pe_in_first),
        .pe_in_last            (pe_in_last),
        .pe_out_valid          (pe_out_valid),
        .pe_out_data           (pe_out_data)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles           (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp;
    int          n_bad;
    int          cyc;
    // model of the job
    bit          m_active;
    bit          m_done_due;
    bit          done_this;
    bit          exp_valid;
    bit          exp_wr;
    int          m_beats;
    int          m_writes;
    // environment statistics
    int          done_cnt;
    int          done_cyc;
    int          wr_cnt;
    int          job_start_cyc;
    logic [7:0]  beat_first;
    logic [7:0]  beat_last;
    // emulated PE
    int          pe_delay;
    bit          pe_extra;
    bit          ready_toggle;
    logic [31:0] pe_acc;
    bit          sched_v [64];
    logic [31:0] sched_d [64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic load_mem(input int base, input int step);
        for (int i = 0; i < IN_N; i++) in_mem[i] = 32'(base + i * step);
    endtask

    task automatic start_now();
        axisif_start  = 1'b1;
        job_start_cyc = cyc;
        @(posedge clk); #1;
        axisif_start  = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_out(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        chk({nm, "_out0"}, out_mem[0], e0);
        chk({nm, "_out1"}, out_mem[1], e1);
        chk({nm, "_out2"}, out_mem[2], e2);
        chk({nm, "_out3"}, out_mem[3], e3);
    endtask

    initial begin
        int d0, w0, n;
        n_cmp = 0; n_bad = 0; cyc = 0;
        m_active = 0; m_done_due = 0; m_beats = 0; m_writes = 0;
        done_cnt = 0; done_cyc = 0; wr_cnt = 0; job_start_cyc = 0;
        beat_first = '0; beat_last = '0;
        pe_delay = 3; pe_extra = 0; ready_toggle = 0; pe_acc = '0;
        for (int i = 0; i < 64; i++) begin sched_v[i] = 0; sched_d[i] = '0; end
        for (int i = 0; i < OUT_N; i++) out_mem[i] = '0;
        load_mem(1, 1);
        rst_n = 1'b0; axisif_start = 1'b0;
        pe_in_ready = 1'b1; pe_out_valid = 1'b0; pe_out_data = '0;

        fork
            forever begin
                @(posedge clk);
                cyc = cyc + 1;
            end
            forever begin
                @(posedge clk); #1;
                pe_in_ready  = ready_toggle ? cyc[0] : 1'b1;
                pe_out_valid = sched_v[cyc % 64];
                pe_out_data  = sched_v[cyc % 64] ? sched_d[cyc % 64] : 32'h0;
            end
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    chk("rst_in_valid", 32'(pe_in_valid), 32'd0);
                    chk("rst_in_adr", 32'(axisif_bufferIn_adr), 32'd0);
                    chk("rst_first_last", 32'({pe_in_first, pe_in_last}), 32'd0);
                    chk("rst_out_wr", 32'(axisif_bufferOut_wr), 32'd0);
                    chk("rst_out_adr", 32'(axisif_bufferOut_adr), 32'd0);
                    chk("rst_out_data", axisif_bufferOut_data, 32'd0);
                    chk("rst_done", 32'(axisif_done), 32'd0);
`ifdef SEQ_PERF_CNT_EN
                    chk("rst_perf", perf_cycles, 32'd0);
`endif
                    m_active = 0; m_done_due = 0;
                    for (int i = 0; i < 64; i++) sched_v[i] = 0;
                end else begin
                    chk("done", 32'(axisif_done), 32'(m_done_due));
                    if (axisif_done) begin done_cnt++; done_cyc = cyc; end
                    exp_valid = m_active && (m_beats < IN_N);
                    chk("in_valid", 32'(pe_in_valid), 32'(exp_valid));
                    if (exp_valid && pe_in_valid) begin
                        chk("in_adr", 32'(axisif_bufferIn_adr), 32'(m_beats));
                        chk("in_first", 32'(pe_in_first), 32'((m_beats % G) == 0));
                        chk("in_last", 32'(pe_in_last), 32'((m_beats % G) == G - 1));
                        chk("in_data", pe_in_data, in_mem[m_beats]);
                        if (pe_in_ready) begin
                            beat_first[m_beats] = pe_in_first;
                            beat_last[m_beats]  = pe_in_last;
                            if ((m_beats % G) == 0) pe_acc = '0;
                            pe_acc = pe_acc + pe_in_data;
                            if ((m_beats % G) == G - 1) begin
                                sched_v[(cyc + pe_delay) % 64] = 1;
                                sched_d[(cyc + pe_delay) % 64] = pe_acc;
                                if (pe_extra && (m_beats / G) == OUT_N - 1) begin
                                    sched_v[(cyc + pe_delay + 1) % 64] = 1;
                                    sched_d[(cyc + pe_delay + 1) % 64] = 32'hDEADBEEF;
                                end
                            end
                            m_beats++;
                        end
                    end
                    exp_wr = pe_out_valid && m_active && (m_writes < OUT_N);
                    chk("out_wr", 32'(axisif_bufferOut_wr), 32'(exp_wr));
                    if (exp_wr && axisif_bufferOut_wr) begin
                        chk("out_adr", 32'(axisif_bufferOut_adr), 32'(m_writes));
                        chk("out_data", axisif_bufferOut_data, pe_out_data);
                        out_mem[m_writes] = axisif_bufferOut_data;
                    end
                    if (axisif_bufferOut_wr) wr_cnt++;
                    if (exp_wr) m_writes++;
                    done_this  = m_done_due;
                    m_done_due = 0;
                    if (m_active && m_beats == IN_N && m_writes == OUT_N) begin
                        m_active   = 0;
                        m_done_due = 1;
                    end else if (!m_active && !done_this && axisif_start) begin
                        m_active = 1; m_beats = 0; m_writes = 0;
                        beat_first = '0; beat_last = '0;
                    end
                end
                sched_v[cyc % 64] = 0;
            end
        join_none

        idle(3);
        rst_n = 1'b1;
        idle(2);

        // nominal job, inputs 1..8
        d0 = done_cnt; w0 = wr_cnt;
        start_now();
        wait_done("nom", d0);
        chk("nom_latency", 32'(done_cyc - job_start_cyc), 32'd12);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_after_done", perf_cycles, 32'd12);
`endif
        idle(4);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_hold", perf_cycles, 32'd12);
`endif
        check_out("nom", 32'd3, 32'd7, 32'd11, 32'd15);
        chk("nom_done_count", 32'(done_cnt - d0), 32'd1);
        chk("nom_write_count", 32'(wr_cnt - w0), 32'd4);

        // pe_in_ready toggling
        load_mem(10, 10);
        ready_toggle = 1;
        d0 = done_cnt;
        start_now();
        wait_done("stall", d0);
        ready_toggle = 0;
        idle(2);
        chk("stall_first_mask", 32'(beat_first), 32'h55);
        chk("stall_last_mask", 32'(beat_last), 32'hAA);
        check_out("stall", 32'd30, 32'd70, 32'd110, 32'd150);

        // stray start during RUN, extra PE result after the fourth write
        load_mem(100, 1);
        pe_extra = 1;
        d0 = done_cnt; w0 = wr_cnt;
        start_now();
        idle(2);
        start_now();
        wait_done("stray", d0);
        idle(4);
        pe_extra = 0;
        chk("stray_done_count", 32'(done_cnt - d0), 32'd1);
        chk("stray_write_count", 32'(wr_cnt - w0), 32'd4);
        check_out("stray", 32'd201, 32'd205, 32'd209, 32'd213);

        // reset in FLUSH after two writes
        load_mem(1, 1);
        pe_delay = 8;
        d0 = done_cnt; w0 = wr_cnt;
        start_now();
        n = 0;
        while ((wr_cnt - w0) < 2 && n < 100) begin @(posedge clk); #1; n++; end
        chk("rst_job_two_writes", 32'(wr_cnt - w0), 32'd2);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("rst_job_no_done", 32'(done_cnt - d0), 32'd0);
        pe_delay = 3;
        load_mem(2, 1);
        d0 = done_cnt;
        start_now();
        wait_done("after_rst", d0);
        chk("after_rst_latency", 32'(done_cyc - job_start_cyc), 32'd12);
        check_out("after_rst", 32'd5, 32'd9, 32'd13, 32'd17);

        // back-to-back jobs: second start the cycle after done
        idle(2);
        load_mem(1, 1);
        d0 = done_cnt;
        start_now();
        wait_done("b2b_a", d0);
        check_out("b2b_a", 32'd3, 32'd7, 32'd11, 32'd15);
        load_mem(11, 1);
        d0 = done_cnt;
        start_now();
        wait_done("b2b_b", d0);
        chk("b2b_latency", 32'(done_cyc - job_start_cyc), 32'd12);
        idle(2);
        check_out("b2b_b", 32'd23, 32'd27, 32'd31, 32'd35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_layer_sequencer.md
# axis_layer_sequencer

Sequences the compute core behind the AXI-Stream interface block's wrapper side. On `axisif_start` it walks the input buffer, streams each word into a processing element (PE) over a valid/ready handshake with group framing, writes PE results into the output buffer, and pulses `axisif_done`. It is the only master of the `axisif_buffer*` ports while the interface block sits between its INFORM and MASTER phases.

## Interface
- `DATA_WIDTH`, 32, word width of buffers and PE.
- `IN_DATA_NUM`, 8, input-buffer words per job.
- `OUT_DATA_NUM`, 4, output-buffer words per job. `IN_DATA_NUM` must be an integer multiple of it. `GROUP = IN_DATA_NUM/OUT_DATA_NUM` inputs are reduced per output.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `axisif_start`  in  1  one-cycle job request from the interface block.
- `axisif_done`  out  1  one-cycle job-complete pulse.
- `axisif_bufferIn_adr`  out  $clog2(IN_DATA_NUM)  input-buffer read address. Read is combinational: data is valid in the same cycle.
- `axisif_bufferIn_data`  in  DATA_WIDTH  input-buffer read data.
- `axisif_bufferOut_adr`  out  $clog2(OUT_DATA_NUM)  output-buffer write address.
- `axisif_bufferOut_data`  out  DATA_WIDTH  output-buffer write data.
- `axisif_bufferOut_wr`  out  1  output-buffer write strobe.
- `pe_in_valid` / `pe_in_ready`  out / in  1 / 1  input-beat handshake to the PE.
- `pe_in_data`  out  DATA_WIDTH  equals `axisif_bufferIn_data`.
- `pe_in_first` / `pe_in_last`  out  1 / 1  first and last beat of a GROUP.
- `pe_out_valid`  in  1  result strobe from the PE. The PE has no backpressure.
- `pe_out_data`  in  DATA_WIDTH  result word.

## Operation
- **States**
  - IDLE: on `axisif_start`, go to RUN.
  - RUN: issue beats. After the beat at index `IN_DATA_NUM-1` is accepted, go to FLUSH.
  - FLUSH: wait for results. When the write at index `OUT_DATA_NUM-1` occurs, go to DONE.
  - DONE: pulse `axisif_done`, then go to IDLE.
- **Input counter `in_cnt`**
  - Cleared in IDLE.
  - Increments when `pe_in_valid & pe_in_ready`.
  - Drives `axisif_bufferIn_adr`.
- **Beat signals**
  - `pe_in_valid` = 1 only in RUN.
  - `pe_in_first` = (`in_cnt % GROUP == 0`).
  - `pe_in_last` = (`in_cnt % GROUP == GROUP-1`).
  - Both are qualified by `pe_in_valid`.
- **Output counter `out_cnt`**
  - Cleared in IDLE.
  - In RUN or FLUSH, each `pe_out_valid` writes `pe_out_data` at `out_cnt` (`axisif_bufferOut_wr` = `pe_out_valid`), then `out_cnt` increments.
  - Results may arrive while RUN is still issuing beats.
- **Boundary conditions**
  - `axisif_start` outside IDLE: ignored.
  - `pe_out_valid` in IDLE or DONE, or after `OUT_DATA_NUM` writes: ignored, no write.
  - A write and the final input acceptance in the same cycle are both honoured.
  - Counters do not wrap within a job. They stop at their terminal value.

## Timing
- All outputs reset to 0; state resets to IDLE.
- Start at cycle t gives the first `pe_in_valid` at t+1 with address 0.
- With `pe_in_ready` held at 1, beats occupy t+1 .. t+IN_DATA_NUM.
- `axisif_done` is high exactly one cycle, in the cycle after the last output write.
- Minimum job latency, start to done: IN_DATA_NUM + PE latency + 2 cycles.
- A stalled `pe_in_ready` holds the address and `pe_in_first`/`pe_in_last` stable.
- Reset mid-job: immediate return to IDLE, counters cleared, no `axisif_done`. Buffer contents are undefined.

## Configuration
- `SEQ_PERF_CNT_EN` defined:
  - Adds output `perf_cycles`, 32 bits.
  - Cleared on the accepted start; increments every non-IDLE cycle; saturates at all-ones.
  - Holds its value after DONE until the next start.
  - Resets to 0.
- Not defined: the port and the counter are absent; the rest of the behaviour is identical.

## Structure
- Package `axis_seq_pkg` holds:
  - the state encoding (IDLE, RUN, FLUSH, DONE) and the state width;
  - helper constants for the `IN_ADR`/`OUT_ADR` widths and GROUP.
- Sub-module: reuse the existing `Counter` for `in_cnt` and `out_cnt`. The FSM stays in this module.

## Test plan
All cases use IN=8, OUT=4, GROUP=2 unless stated.
- Nominal, `pe_in_ready`=1, PE echoes the sum of each pair after 2 cycles, inputs 1..8 → output buffer holds 3, 7, 11, 15; `axisif_done` pulses once at cycle 12 after start.
- `pe_in_ready` toggles 1,0,1,0 → address and `pe_in_first`/`pe_in_last` stay stable during stalls; 8 beats total; `pe_in_first` on beats 0/2/4/6, `pe_in_last` on 1/3/5/7.
- Second `axisif_start` asserted in RUN, then a fifth `pe_out_valid` after four writes → both ignored; no extra write; a single done pulse.
- `rst_n` low in FLUSH after 2 writes → all outputs 0 and state IDLE; a new start runs a full correct job.
- `SEQ_PERF_CNT_EN` defined, nominal job → `perf_cycles` = 12 after done, stable until the next start.
- Back-to-back jobs, start issued the cycle after done → the second job's results overwrite addresses 0..3 correctly.
